// File: rtl/shift_frame_controller_if.sv
// Bundle between a word source and the frame controller: the parallel
// handshake with its abort, plus the serial outputs and frame strobes.
interface shift_frame_controller_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             ser_out;
  logic             ser_en;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  // Source side: presents words and aborts, observes the serial stream.
  modport master (
    output in_valid,
    output in_data,
    output abort,
    input  in_ready,
    input  ser_out,
    input  ser_en,
    input  frame_start,
    input  frame_done,
    input  busy
  );

  // Controller side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  abort,
    output in_ready,
    output ser_out,
    output ser_en,
    output frame_start,
    output frame_done,
    output busy
  );
endinterface

// File: rtl/shift_frame_controller.sv
// Serialises parallel words MSB-first, one bit per clock, brackets each word
// with frame_start/frame_done strobes and forces GAP_CYCLES idle cycles after
// every frame, whether it completed or was aborted.
module shift_frame_controller #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  shift_frame_controller_if.slave if_bus
);

  localparam int unsigned BcntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GcntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  // With no gap configured a finished or aborted frame returns straight to idle.
  localparam state_e StAfterFrame = (GAP_CYCLES == 0) ? StIdle : StGap;

  localparam logic [BcntW-1:0] BcntLast = BcntW'(WIDTH - 1);
  localparam logic [GcntW-1:0] GcntLoad = GcntW'(GAP_CYCLES);
  localparam logic [GcntW-1:0] GcntOne  = GcntW'(1);

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_d;
  logic [BcntW-1:0] r_bcnt;
  logic [BcntW-1:0] w_bcnt_d;
  logic [GcntW-1:0] r_gcnt;
  logic [GcntW-1:0] w_gcnt_d;

  logic w_in_ready;
  logic w_accept;
  logic w_in_shift;
  logic w_last_bit;

  // Ready is the only combinational output; reset and abort both mask it.
  assign w_in_ready = (r_state == StIdle) & ~if_bus.abort & ~i_rst;
  assign w_accept   = if_bus.in_valid & w_in_ready;
  assign w_in_shift = (r_state == StShift);
  assign w_last_bit = (r_bcnt == '0);

  // Next-state and datapath update for load, shift and gap sequencing.
  always_comb begin
    w_state_d = r_state;
    w_shreg_d = r_shreg;
    w_bcnt_d  = r_bcnt;
    w_gcnt_d  = r_gcnt;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_shreg_d = if_bus.in_data;
          w_bcnt_d  = BcntLast;
          w_state_d = StShift;
        end
      end

      StShift: begin
        w_shreg_d = {r_shreg[WIDTH-2:0], 1'b0};
        w_bcnt_d  = r_bcnt - BcntW'(1);
        if (if_bus.abort || w_last_bit) begin
          w_state_d = StAfterFrame;
          w_gcnt_d  = GcntLoad;
          w_bcnt_d  = '0;
          if (if_bus.abort) begin
            w_shreg_d = '0;
          end
        end
      end

      StGap: begin
        w_gcnt_d = r_gcnt - GcntW'(1);
        // Abort has no effect here; the gap always runs to completion.
        if (r_gcnt <= GcntOne) begin
          w_state_d = StIdle;
          w_gcnt_d  = '0;
        end
      end

      default: begin
        w_state_d = StIdle;
        w_shreg_d = '0;
        w_bcnt_d  = '0;
        w_gcnt_d  = '0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset discards any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_shreg <= w_shreg_d;
      r_bcnt  <= w_bcnt_d;
      r_gcnt  <= w_gcnt_d;
    end
  end

  // Serial outputs are decoded purely from registered state, shreg and bcnt.
  assign if_bus.in_ready    = w_in_ready;
  assign if_bus.ser_out     = w_in_shift & r_shreg[WIDTH-1];
  assign if_bus.ser_en      = w_in_shift;
  assign if_bus.frame_start = w_in_shift & (r_bcnt == BcntLast);
  assign if_bus.frame_done  = w_in_shift & w_last_bit;
  assign if_bus.busy        = (r_state != StIdle);

endmodule

// File: tb/tb_shift_frame_controller.sv
// Directed bench: one DUT with WIDTH=4/GAP_CYCLES=1, one with GAP_CYCLES=0.
module tb_shift_frame_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_frame_controller_if #(.WIDTH(4)) bus_a ();
  shift_frame_controller_if #(.WIDTH(4)) bus_b ();

  shift_frame_controller #(.WIDTH(4), .GAP_CYCLES(1)) u_dut_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .if_bus (bus_a)
  );

  shift_frame_controller #(.WIDTH(4), .GAP_CYCLES(0)) u_dut_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .if_bus (bus_b)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus_a.ser_out, bus_a.ser_en, bus_a.frame_start, bus_a.frame_done, bus_a.busy,
         bus_a.in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs_a: got %b want 000000", {bus_a.ser_out, bus_a.ser_en,
               bus_a.frame_start, bus_a.frame_done, bus_a.busy, bus_a.in_ready});
    end
    checks++;
    if ({bus_b.ser_en, bus_b.busy, bus_b.in_ready} !== 3'b0) begin
      errors++;
      $display("FAIL reset_outs_b: got %b want 000",
               {bus_b.ser_en, bus_b.busy, bus_b.in_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_a.in_ready, bus_b.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 11", {bus_a.in_ready, bus_b.in_ready});
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b1011;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_a.ser_en, bus_a.ser_out, bus_a.frame_start, bus_a.frame_done, bus_a.busy} !==
          {1'b1, exp_bits[3-i], (i == 0), (i == 3), 1'b1}) begin
        errors++;
        $display("FAIL single_bit[%0d]: got en/out/st/dn/busy %b want %b", i,
                 {bus_a.ser_en, bus_a.ser_out, bus_a.frame_start, bus_a.frame_done,
                  bus_a.busy}, {1'b1, exp_bits[3-i], (i == 0), (i == 3), 1'b1});
      end
      tick();
    end
    checks++;
    if ({bus_a.ser_en, bus_a.ser_out, bus_a.busy, bus_a.in_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL single_gap: got en/out/busy/rdy %b want 0010",
               {bus_a.ser_en, bus_a.ser_out, bus_a.busy, bus_a.in_ready});
    end
    tick();
    checks++;
    if ({bus_a.busy, bus_a.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_idle: got busy/rdy %b want 01", {bus_a.busy, bus_a.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0110;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b1011;
    tick();
    bus_a.in_data = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_a.ser_en, bus_a.ser_out} !== {1'b1, exp_bits[7-i]}) begin
        errors++;
        $display("FAIL b2b_first[%0d]: got en/out %b want %b", i,
                 {bus_a.ser_en, bus_a.ser_out}, {1'b1, exp_bits[7-i]});
      end
      tick();
    end
    checks++;
    if ({bus_a.ser_en, bus_a.in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got en/rdy %b want 00", {bus_a.ser_en, bus_a.in_ready});
    end
    tick();
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_ready: got %b want 1", bus_a.in_ready);
    end
    tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_a.ser_en, bus_a.ser_out, bus_a.frame_start} !==
          {1'b1, exp_bits[3-i], (i == 0)}) begin
        errors++;
        $display("FAIL b2b_second[%0d]: got en/out/st %b want %b", i,
                 {bus_a.ser_en, bus_a.ser_out, bus_a.frame_start},
                 {1'b1, exp_bits[3-i], (i == 0)});
      end
      tick();
    end
    tick();
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end_ready: got %b want 1", bus_a.in_ready);
    end
  endtask

  task automatic test_abort();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b1111;
    tick();
    bus_a.in_valid = 1'b0;
    checks++;
    if ({bus_a.ser_en, bus_a.ser_out, bus_a.frame_done} !== 3'b110) begin
      errors++;
      $display("FAIL abort_k1: got en/out/dn %b want 110",
               {bus_a.ser_en, bus_a.ser_out, bus_a.frame_done});
    end
    tick();
    bus_a.abort = 1'b1;
    #1;
    checks++;
    if ({bus_a.ser_en, bus_a.frame_done} !== 2'b10) begin
      errors++;
      $display("FAIL abort_k2: got en/dn %b want 10", {bus_a.ser_en, bus_a.frame_done});
    end
    tick();
    bus_a.abort = 1'b0;
    checks++;
    if ({bus_a.ser_en, bus_a.ser_out, bus_a.frame_done, bus_a.busy, bus_a.in_ready} !==
        5'b00010) begin
      errors++;
      $display("FAIL abort_k3: got en/out/dn/busy/rdy %b want 00010",
               {bus_a.ser_en, bus_a.ser_out, bus_a.frame_done, bus_a.busy, bus_a.in_ready});
    end
    tick();
    checks++;
    if ({bus_a.busy, bus_a.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_k4: got busy/rdy %b want 01", {bus_a.busy, bus_a.in_ready});
    end
  endtask

  task automatic test_abort_last_bit();
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b1001;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    tick();
    tick();
    bus_a.abort = 1'b1;
    #1;
    checks++;
    if ({bus_a.ser_en, bus_a.ser_out, bus_a.frame_done} !== 3'b111) begin
      errors++;
      $display("FAIL abort_last_done: got en/out/dn %b want 111",
               {bus_a.ser_en, bus_a.ser_out, bus_a.frame_done});
    end
    tick();
    // Abort held through the gap must not change the gap length.
    checks++;
    if ({bus_a.ser_en, bus_a.busy, bus_a.in_ready} !== 3'b010) begin
      errors++;
      $display("FAIL abort_last_gap: got en/busy/rdy %b want 010",
               {bus_a.ser_en, bus_a.busy, bus_a.in_ready});
    end
    tick();
    bus_a.abort = 1'b0;
    #1;
    checks++;
    if ({bus_a.busy, bus_a.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_last_idle: got busy/rdy %b want 01", {bus_a.busy, bus_a.in_ready});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp_bits;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b1100;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_a.ser_out, bus_a.ser_en, bus_a.frame_start, bus_a.frame_done, bus_a.busy,
         bus_a.in_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL rst_mid_outs: got %b want 000001", {bus_a.ser_out, bus_a.ser_en,
               bus_a.frame_start, bus_a.frame_done, bus_a.busy, bus_a.in_ready});
    end
    exp_bits = 4'b0001;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'b0001;
    tick();
    bus_a.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_a.ser_en, bus_a.ser_out, bus_a.frame_start, bus_a.frame_done} !==
          {1'b1, exp_bits[3-i], (i == 0), (i == 3)}) begin
        errors++;
        $display("FAIL rst_mid_frame[%0d]: got en/out/st/dn %b want %b", i,
                 {bus_a.ser_en, bus_a.ser_out, bus_a.frame_start, bus_a.frame_done},
                 {1'b1, exp_bits[3-i], (i == 0), (i == 3)});
      end
      tick();
    end
    tick();
    checks++;
    if (bus_a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_end_ready: got %b want 1", bus_a.in_ready);
    end
  endtask

  task automatic test_no_gap();
    logic [3:0] exp_bits;
    exp_bits = 4'b1000;
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 4'b1000;
    tick();
    bus_b.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus_b.ser_en, bus_b.ser_out, bus_b.frame_done} !== {1'b1, exp_bits[3-i], (i == 3)})
      begin
        errors++;
        $display("FAIL nogap_bit[%0d]: got en/out/dn %b want %b", i,
                 {bus_b.ser_en, bus_b.ser_out, bus_b.frame_done},
                 {1'b1, exp_bits[3-i], (i == 3)});
      end
      tick();
    end
    checks++;
    if ({bus_b.ser_en, bus_b.busy, bus_b.in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL nogap_idle: got en/busy/rdy %b want 001",
               {bus_b.ser_en, bus_b.busy, bus_b.in_ready});
    end
    bus_b.in_valid = 1'b1;
    bus_b.abort    = 1'b1;
    #1;
    checks++;
    if (bus_b.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort_ready: got %b want 0", bus_b.in_ready);
    end
    tick();
    bus_b.in_valid = 1'b0;
    bus_b.abort    = 1'b0;
    #1;
    checks++;
    if ({bus_b.ser_en, bus_b.busy, bus_b.in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL idle_abort_noaccept: got en/busy/rdy %b want 001",
               {bus_b.ser_en, bus_b.busy, bus_b.in_ready});
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 4'b0000;
    bus_a.abort    = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 4'b0000;
    bus_b.abort    = 1'b0;

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_abort_last_bit();
    test_reset_mid_frame();
    test_no_gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_frame_controller.md
# shift_frame_controller

Sequencer for the team's serial shift-register datapath. It accepts parallel words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock. It brackets every word with frame strobes and enforces a configurable idle gap between frames. It sits between a word-producing source and any serial consumer, such as a SISO register chain, and owns all load/shift/gap sequencing.

## Interface
- WIDTH, 4, bits per frame; legal range ≥ 2
- GAP_CYCLES, 1, idle cycles forced after every frame (completed or aborted); legal range ≥ 0
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  source has a word on in_data
- in_data  in  WIDTH  parallel word, bit WIDTH-1 sent first
- in_ready  out  1  controller can accept a word this cycle
- abort  in  1  terminate current frame
- ser_out  out  1  serial data bit
- ser_en  out  1  high in each cycle that ser_out carries a valid bit
- frame_start  out  1  one-cycle pulse with the first bit
- frame_done  out  1  one-cycle pulse with the last bit of a completed frame
- busy  out  1  controller not in IDLE

## Operation
- States: IDLE, SHIFT, GAP.
- Internal registers:
  - shift register `shreg` of width WIDTH.
  - bit counter `bcnt` of width clog2(WIDTH).
  - gap counter `gcnt` of width clog2(GAP_CYCLES+1), minimum 1 bit.
- `in_ready = (state==IDLE) & ~abort & ~rst`. This is combinational, and it is the only combinational output.
- Accept event: `in_valid & in_ready` at a rising edge. On accept:
  - load `shreg` with in_data.
  - set `bcnt` to WIDTH-1.
  - go to SHIFT.
- SHIFT behaviour:
  - `ser_out = shreg[WIDTH-1]`, `ser_en = 1`.
  - Each edge shifts `shreg` left by 1, zero-filling bit 0, and decrements `bcnt`.
  - `frame_start = 1` only in the first SHIFT cycle (`bcnt==WIDTH-1`).
  - `frame_done = 1` in the cycle where `bcnt==0`.
- SHIFT exit:
  - When `bcnt==0`, the next state is GAP with `gcnt` loaded to GAP_CYCLES.
  - If GAP_CYCLES==0, the next state is IDLE instead.
- GAP behaviour:
  - `ser_en = 0`, `ser_out = 0`.
  - `gcnt` decrements each edge.
  - When `gcnt==1`, the next state is IDLE.
- abort sampled high in SHIFT:
  - next state is GAP (or IDLE if GAP_CYCLES==0).
  - `shreg` is cleared.
  - no frame_done is issued for that frame. If abort coincides with `bcnt==0`, frame_done is still asserted, since the last bit is already on the line; only the state change follows abort.
- abort in IDLE blocks acceptance for that cycle. abort in GAP has no effect.
- in_data and in_valid are ignored outside IDLE. The source must hold in_valid until in_ready is seen.
- In IDLE: `ser_out = 0`, `ser_en = 0`, `frame_start = 0`, `frame_done = 0`.
- All outputs except in_ready are decoded from registered state and registered `shreg`/`bcnt`. They are glitch-free relative to clk.

## Timing
- Reset state (rst high at an edge, regardless of state):
  - state IDLE, `shreg` 0, `bcnt` 0, `gcnt` 0.
  - ser_out 0, ser_en 0, frame_start 0, frame_done 0, busy 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- rst has priority over accept and abort.
- Reset mid-frame discards the frame with no frame_done.
- Frame timeline, for an accept at edge k:
  - bits appear in cycles k+1 … k+WIDTH.
  - frame_start in cycle k+1; frame_done in cycle k+WIDTH.
  - GAP occupies cycles k+WIDTH+1 … k+WIDTH+GAP_CYCLES.
  - IDLE with in_ready=1 in cycle k+WIDTH+GAP_CYCLES+1.
- Latency: 1 cycle from accept to first bit.
- Minimum frame period: WIDTH+GAP_CYCLES+1 cycles. Back-to-back frames always have at least one IDLE cycle.
- Abort latency: abort high during cycle j (in SHIFT) means ser_en=0 from cycle j+1.

## Test plan
- Single frame, WIDTH=4, GAP_CYCLES=1, in_data=4'b1011 accepted at edge k:
  - ser_out=1,0,1,1 with ser_en=1 in cycles k+1..k+4.
  - frame_start only at k+1; frame_done only at k+4.
  - ser_en=0 at k+5; in_ready=1 at k+6.
- Back-to-back: in_valid held high with 4'b1011, then 4'b0110 presented after the first handshake:
  - second accept at end of cycle k+6.
  - ser_out=0,1,1,0 in k+7..k+10.
  - in_data changes during SHIFT do not affect the bits in flight.
- Abort: 4'b1111 accepted at k, abort=1 during cycle k+2:
  - ser_en=1 only in k+1..k+2.
  - no frame_done; busy through k+3; in_ready=1 at k+4.
- Abort on last bit: abort=1 in cycle k+4 → frame_done=1 in k+4, then GAP.
- Reset mid-operation: rst=1 during cycle k+2 of a frame:
  - next cycle shows all outputs at reset values and no frame_done.
  - accept of 4'b0001 after rst falls produces a correct frame.
- GAP_CYCLES=0 build: 4'b1000 accepted at k → bits 1,0,0,0 in k+1..k+4, in_ready=1 at k+5. Also, in_valid=1 with abort=1 in IDLE → no accept, in_ready=0 that cycle.
